eq_band_sequencer: RTL and testbench

Per-sample scheduler for the equalizer datapath. On each ADC sample it time-shares one band-filter unit across N_BAND bands. Each band output is scaled by that band's gain and summed into one saturated output sample for the DAC.
Sits between the ADC controller (sample strobe) and the DAC controller. The UI gain registers feed i_gain.

---
 rtl/eq_pkg.sv | 30 +++
 rtl/eq_gain_mac.sv | 49 ++++
 rtl/eq_band_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_eq_band_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer band sequencer.
//   DW, GW, GFRAC : default sample width, gain width and gain fractional bits
//   state_t       : sequencer FSM states
//   sat_dw()      : clamps a wide signed accumulator to the DW-bit sample range
package eq_pkg;

  localparam int DW     = 16;
  localparam int GW     = 16;
  localparam int GFRAC  = 14;
  localparam int SAT_IW = 64;

  localparam logic signed [SAT_IW-1:0] SAT_HI = {{(SAT_IW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SAT_IW-1:0] SAT_LO = {{(SAT_IW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  // Callers sign-extend their accumulator to SAT_IW bits before calling.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [SAT_IW-1:0] acc);
    if (acc > SAT_HI)      return SAT_HI[DW-1:0];
    else if (acc < SAT_LO) return SAT_LO[DW-1:0];
    else                   return acc[DW-1:0];
  endfunction

endpackage

// File: rtl/eq_gain_mac.sv
// Gain multiply-accumulate for the band sequencer.
// Combinational signed multiply of one band result by its gain, arithmetic
// shift by GFRAC, accumulated into a registered wide accumulator. The read
// port returns the accumulator saturated to the sample range.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   clr          : zero the accumulator
//   load         : load load_val (sign-extended) into the accumulator
//   en           : accumulate (result * gain) >>> GFRAC
//   result, gain : current band output and its gain (Q2.14)
//   sat_out      : saturated accumulator value
module eq_gain_mac
  import eq_pkg::*;
#(
  parameter int DW    = eq_pkg::DW,
  parameter int GW    = eq_pkg::GW,
  parameter int GFRAC = eq_pkg::GFRAC,
  parameter int AW    = eq_pkg::DW + eq_pkg::GW + 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 clr,
  input  logic                 load,
  input  logic signed [DW-1:0] load_val,
  input  logic                 en,
  input  logic signed [DW-1:0] result,
  input  logic signed [GW-1:0] gain,
  output logic signed [DW-1:0] sat_out
);

  localparam int PW = DW + GW;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;
  logic signed [AW-1:0] acc_q;

  assign prod    = PW'(result) * PW'(gain);
  assign prod_sh = prod >>> GFRAC;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     acc_q <= '0;
    else if (clr)  acc_q <= '0;
    else if (load) acc_q <= AW'(load_val);
    else if (en)   acc_q <= acc_q + AW'(prod_sh);
  end

  assign sat_out = sat_dw({{(SAT_IW-AW){acc_q[AW-1]}}, acc_q});

endmodule

// File: rtl/eq_band_sequencer.sv
// Per-sample equalizer scheduler. Each ADC sample is sent through one shared
// band-filter unit once per band; each band result is scaled by a gain
// snapshot taken at sample start and summed into one saturated output sample.
// With i_enable low the sample bypasses the filter entirely.
// Optional build macro EQ_SEQ_TIMEOUT_EN adds a per-band watchdog (TIMEOUT
// cycles) that forces a missing band result to 0, plus the sticky o_timeout.
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_enable              : 1 equalize, 0 bypass (sampled only when idle)
//   i_sample_valid/sample : input sample strobe and data
//   i_gain                : packed per-band gains, band k at [k*GW +: GW]
//   o_flt_req/band/data   : request to the shared filter, held until i_flt_ack
//   i_flt_ack/valid/result: filter accept pulse, result pulse and data
//   o_valid/o_data        : output strobe and saturated sample (held)
//   o_busy                : sequencer not idle
//   o_overrun             : sticky, sample arrived while busy
//   o_timeout             : sticky watchdog flag (EQ_SEQ_TIMEOUT_EN only)
//   i_clr                 : clears sticky flags, wins over a same-cycle set
//
// state  | meaning
// S_IDLE | waiting for a sample strobe
// S_REQ  | requesting the filter for the current band
// S_WAIT | request accepted, waiting for the band result
// S_ACC  | accumulating result * gain for the current band
// S_OUT  | presenting the output sample for one cycle
module eq_band_sequencer
  import eq_pkg::*;
#(
`ifdef EQ_SEQ_TIMEOUT_EN
  parameter int TIMEOUT = 64,
`endif
  parameter int N_BAND = 7,
  parameter int DW     = eq_pkg::DW,
  parameter int GW     = eq_pkg::GW,
  parameter int GFRAC  = eq_pkg::GFRAC
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_sample_valid,
  input  logic signed [DW-1:0]       i_sample,
  input  logic [N_BAND*GW-1:0]       i_gain,
  output logic                       o_flt_req,
  output logic [$clog2(N_BAND)-1:0]  o_flt_band,
  output logic signed [DW-1:0]       o_flt_data,
  input  logic                       i_flt_ack,
  input  logic                       i_flt_valid,
  input  logic signed [DW-1:0]       i_flt_result,
  output logic                       o_valid,
  output logic signed [DW-1:0]       o_data,
  output logic                       o_busy,
  output logic                       o_overrun,
`ifdef EQ_SEQ_TIMEOUT_EN
  output logic                       o_timeout,
`endif
  input  logic                       i_clr
);

  localparam int BW = $clog2(N_BAND);
  localparam int AW = DW + GW + BW;
  localparam logic [BW-1:0] BAND_LAST = BW'(N_BAND - 1);

  state_t                state_q, state_d;
  logic [BW-1:0]         band_q;
  logic signed [DW-1:0]  sample_q;
  logic [N_BAND*GW-1:0]  gain_snap_q;
  logic signed [DW-1:0]  result_q;
  logic signed [DW-1:0]  data_q;
  logic                  overrun_q;

  logic                  start_eq;
  logic                  start_byp;
  logic                  capture;
  logic signed [DW-1:0]  result_d;
  logic                  acc_en;
  logic signed [DW-1:0]  mac_sat;

`ifdef EQ_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q;
  logic          tmo_hit;
  logic          timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    start_eq  = 1'b0;
    start_byp = 1'b0;
    capture   = 1'b0;
    result_d  = i_flt_result;
    acc_en    = 1'b0;
    o_flt_req = 1'b0;
`ifdef EQ_SEQ_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_sample_valid) begin
          if (i_enable) begin
            start_eq = 1'b1;
            state_d  = S_REQ;
          end else begin
            start_byp = 1'b1;
            state_d   = S_OUT;
          end
        end
      end
      S_REQ: begin
        o_flt_req = 1'b1;
        if (i_flt_ack && i_flt_valid) begin
          capture = 1'b1;
          state_d = S_ACC;
        end else if (i_flt_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flt_valid) begin
          capture = 1'b1;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_en  = 1'b1;
        state_d = (band_q == BAND_LAST) ? S_OUT : S_REQ;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef EQ_SEQ_TIMEOUT_EN
    // Last watchdog cycle with no result: substitute 0 and move on.
    if ((state_q == S_REQ || state_q == S_WAIT) && !capture && tmr_q == TW'(1)) begin
      tmo_hit  = 1'b1;
      capture  = 1'b1;
      result_d = '0;
      state_d  = S_ACC;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      band_q      <= '0;
      sample_q    <= '0;
      gain_snap_q <= '0;
      result_q    <= '0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_eq) begin
        band_q      <= '0;
        sample_q    <= i_sample;
        gain_snap_q <= i_gain;
      end else if (acc_en && band_q != BAND_LAST) begin
        band_q <= band_q + 1'b1;
      end
      if (capture) result_q <= result_d;
      if (state_q == S_OUT) data_q <= mac_sat;
      if (i_clr)                                       overrun_q <= 1'b0;
      else if (i_sample_valid && state_q != S_IDLE)    overrun_q <= 1'b1;
    end
  end

`ifdef EQ_SEQ_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d == S_REQ && state_q != S_REQ)
        tmr_q <= TW'(TIMEOUT);
      else if ((state_q == S_REQ || state_q == S_WAIT) && tmr_q != '0)
        tmr_q <= tmr_q - 1'b1;
      if (i_clr)        timeout_q <= 1'b0;
      else if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`endif

  eq_gain_mac #(
    .DW    (DW),
    .GW    (GW),
    .GFRAC (GFRAC),
    .AW    (AW)
  ) u_mac (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .clr      (start_eq),
    .load     (start_byp),
    .load_val (i_sample),
    .en       (acc_en),
    .result   (result_q),
    .gain     (gain_snap_q[int'(band_q)*GW +: GW]),
    .sat_out  (mac_sat)
  );

  assign o_flt_band = (state_q == S_REQ) ? band_q : '0;
  assign o_flt_data = (state_q == S_REQ) ? sample_q : '0;
  assign o_valid    = (state_q == S_OUT);
  assign o_data     = (state_q == S_OUT) ? mac_sat : data_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_eq_band_sequencer.sv
module tb_eq_band_sequencer;

  localparam int N  = 7;
  localparam int DW = 16;
  localparam int GW = 16;

  logic                 clk;
  logic                 rst;
  logic                 i_enable;
  logic                 i_sample_valid;
  logic signed [DW-1:0] i_sample;
  logic [N*GW-1:0]      i_gain;
  logic                 o_flt_req;
  logic [2:0]           o_flt_band;
  logic signed [DW-1:0] o_flt_data;
  logic                 flt_ack;
  logic                 flt_valid;
  logic signed [DW-1:0] flt_result;
  logic                 o_valid;
  logic signed [DW-1:0] o_data;
  logic                 o_busy;
  logic                 o_overrun;
  logic                 i_clr;
`ifdef EQ_SEQ_TIMEOUT_EN
  logic                 o_timeout;
`endif

  int vectors = 0;
  int miscompares = 0;

  eq_band_sequencer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (i_enable),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .i_gain         (i_gain),
    .o_flt_req      (o_flt_req),
    .o_flt_band     (o_flt_band),
    .o_flt_data     (o_flt_data),
    .i_flt_ack      (flt_ack),
    .i_flt_valid    (flt_valid),
    .i_flt_result   (flt_result),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun),
`ifdef EQ_SEQ_TIMEOUT_EN
    .o_timeout      (o_timeout),
`endif
    .i_clr          (i_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- filter unit model ----------------
  // mode 0: result = data (identity); mode 1: result = 100*(band+1)
  int ack_dly = 0;
  int res_dly = 0;
  int mode = 0;
  int stall_band = -1;
  int req_age;
  int since_ack;
  int pend_band;
  logic waiting;
  logic signed [DW-1:0] pend_res;

  function automatic logic signed [DW-1:0] fres(input int m, input int b, input logic signed [DW-1:0] d);
    return (m == 1) ? 16'(100 * (b + 1)) : d;
  endfunction

  assign flt_ack    = o_flt_req && (req_age == ack_dly);
  assign flt_valid  = (flt_ack && res_dly == 0 && int'(o_flt_band) != stall_band) ||
                      (waiting && since_ack == res_dly && pend_band != stall_band);
  assign flt_result = (flt_ack && res_dly == 0) ? fres(mode, int'(o_flt_band), o_flt_data) : pend_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      req_age   <= 0;
      since_ack <= 0;
      waiting   <= 1'b0;
      pend_band <= -1;
      pend_res  <= '0;
    end else begin
      if (o_flt_req && !flt_ack) req_age <= req_age + 1;
      else                       req_age <= 0;
      if (flt_ack && !flt_valid) begin
        waiting   <= 1'b1;
        since_ack <= 1;
        pend_band <= int'(o_flt_band);
        pend_res  <= fres(mode, int'(o_flt_band), o_flt_data);
      end else if (flt_valid) begin
        waiting <= 1'b0;
      end else if (waiting) begin
        since_ack <= since_ack + 1;
      end
    end
  end

  // ---------------- monitors ----------------
  int band_log[$];
  int req_cycles = 0;
  int valid_cnt = 0;
  int unstable = 0;
  logic prev_hold = 1'b0;
  logic [2:0] prev_band;
  logic signed [DW-1:0] prev_data;

  always @(posedge clk) begin
    if (o_flt_req && flt_ack) band_log.push_back(int'(o_flt_band));
    if (o_flt_req) req_cycles <= req_cycles + 1;
    if (o_valid) valid_cnt <= valid_cnt + 1;
    if (o_flt_req && prev_hold && (o_flt_band != prev_band || o_flt_data != prev_data))
      unstable <= unstable + 1;
    prev_hold <= o_flt_req && !flt_ack;
    prev_band <= o_flt_band;
    prev_data <= o_flt_data;
  end

  // ---------------- reference model ----------------
  function automatic logic signed [63:0] ref_eq(input logic signed [DW-1:0] s, input logic [N*GW-1:0] g,
                                                input int m, input int stall);
    longint sum;
    longint r;
    longint gk;
    sum = 0;
    for (int k = 0; k < N; k++) begin
      r = (m == 1) ? longint'(100 * (k + 1)) : longint'(s);
      if (k == stall) r = 0;
      gk = longint'($signed(g[k*GW +: GW]));
      sum += (r * gk) >>> 14;
    end
    if (sum > 32767) sum = 32767;
    else if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  function automatic int exp_latency(input logic en, input int a, input int r);
    return en ? 1 + N * (a + r + 2) : 1;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe one sample and wait (bounded) for o_valid; optional extra strobe
  // and mid-sample gain change at given cycle offsets.
  task automatic do_sample(input logic signed [DW-1:0] s, input logic en, input int exp_lat,
                           input logic signed [DW-1:0] exp_d, input int extra_at, input int chg_at,
                           input logic [N*GW-1:0] new_g, input string tag);
    int lat;
    bit seen;
    @(posedge clk); #1;
    i_sample = s;
    i_enable = en;
    i_sample_valid = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      i_sample_valid = (lat == extra_at);
      if (lat == extra_at) i_sample = ~s;
      if (lat == chg_at) i_gain = new_g;
      seen = o_valid;
    end
    i_sample_valid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, o_data, exp_d);
    @(posedge clk); #1;
    check({tag, "_valid_one_cycle"}, o_valid, 1'b0);
    check({tag, "_data_held"}, o_data, exp_d);
  endtask

  logic [N*GW-1:0] g_unity;
  logic [N*GW-1:0] g_alt;
  logic [N*GW-1:0] g_rand;
  logic signed [DW-1:0] s_rand;
  logic en_rand;
  int n0;
  int r0;
  int v0;

  initial begin
    rst = 1'b1;
    i_enable = 1'b1;
    i_sample_valid = 1'b0;
    i_sample = '0;
    i_clr = 1'b0;
    for (int k = 0; k < N; k++) begin
      g_unity[k*GW +: GW] = 16'h4000;
      case (k % 3)
        0:       g_alt[k*GW +: GW] = 16'h4000;
        1:       g_alt[k*GW +: GW] = 16'h0000;
        default: g_alt[k*GW +: GW] = 16'h2000;
      endcase
    end
    i_gain = g_unity;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_req", o_flt_req, 1'b0);
    check("rst_data", o_data, 16'sd0);
    check("rst_overrun", o_overrun, 1'b0);
    rst = 1'b0;

    // identity filter, unity gains, zero-wait
    mode = 0; ack_dly = 0; res_dly = 0;
    n0 = band_log.size();
    do_sample(16'sd1000, 1'b1, exp_latency(1'b1, 0, 0), 16'sd7000, -1, -1, g_unity, "unity_1000");
    check("unity_pairs", band_log.size() - n0, N);
    for (int k = 0; k < N; k++) check("unity_band_order", band_log[n0 + k], k);
    do_sample(16'sd10000, 1'b1, 15, ref_eq(16'sd10000, g_unity, 0, -1), -1, -1, g_unity, "sat_pos");
    check("sat_pos_value", o_data, 16'sd32767);
    do_sample(-16'sd10000, 1'b1, 15, -16'sd32768, -1, -1, g_unity, "sat_neg");

    // weighted bands; gain change mid-sample only affects the next sample
    mode = 1;
    i_gain = g_alt;
    do_sample(16'sd5, 1'b1, 15, ref_eq(16'sd5, g_alt, 1, -1), -1, 5, g_unity, "weighted");
    check("weighted_value", o_data, 16'sd1650);
    do_sample(16'sd5, 1'b1, 15, ref_eq(16'sd5, g_unity, 1, -1), -1, -1, g_unity, "new_gain");

    // slow filter, overrun and clear
    mode = 0; ack_dly = 3; res_dly = 2;
    do_sample(16'sd1000, 1'b1, 50, 16'sd7000, 10, -1, g_unity, "slow");
    check("slow_req_stable", unstable, 0);
    check("overrun_set", o_overrun, 1'b1);
    i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    check("overrun_clr", o_overrun, 1'b0);

    // bypass
    r0 = req_cycles;
    do_sample(-16'sd1234, 1'b0, 1, -16'sd1234, -1, -1, g_unity, "bypass");
    check("bypass_no_req", req_cycles - r0, 0);

    // reset while waiting for a result
    ack_dly = 0; res_dly = 5;
    v0 = valid_cnt;
    @(posedge clk); #1;
    i_enable = 1'b1;
    i_sample = 16'sd300;
    i_sample_valid = 1'b1;
    @(posedge clk); #1;
    i_sample_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_busy", o_busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_req", o_flt_req, 1'b0);
    check("midrst_data", o_data, 16'sd0);
    check("midrst_valid", o_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_valid", valid_cnt - v0, 0);

    // randomized samples, gains and filter timing
    for (int it = 0; it < 16; it++) begin
      ack_dly = $urandom_range(0, 3);
      res_dly = $urandom_range(0, 3);
      mode = $urandom_range(0, 1);
      en_rand = ($urandom_range(0, 4) != 0);
      s_rand = 16'($urandom);
      for (int k = 0; k < N; k++) g_rand[k*GW +: GW] = 16'($urandom);
      i_gain = g_rand;
      do_sample(s_rand, en_rand, exp_latency(en_rand, ack_dly, res_dly),
                en_rand ? 16'(ref_eq(s_rand, g_rand, mode, -1)) : s_rand,
                -1, -1, g_rand, "random");
    end

`ifdef EQ_SEQ_TIMEOUT_EN
    mode = 0; ack_dly = 0; res_dly = 1; stall_band = 3;
    i_gain = g_unity;
    do_sample(16'sd1000, 1'b1, 1 + (N - 1) * 3 + 65, 16'(ref_eq(16'sd1000, g_unity, 0, 3)),
              -1, -1, g_unity, "timeout");
    check("timeout_flag", o_timeout, 1'b1);
    stall_band = -1;
    i_clr = 1'b1;
    @(posedge clk); #1;
    i_clr = 1'b0;
    check("timeout_clr", o_timeout, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
